// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: controller states, DR selection and
// instruction codes used by the TAP responder.
package jtag_pkg;

    // The 16 TAP controller states.
    typedef enum logic [3:0] {
        TAP_TLR      = 4'd0,
        TAP_RTI      = 4'd1,
        TAP_SEL_DR   = 4'd2,
        TAP_CAP_DR   = 4'd3,
        TAP_SH_DR    = 4'd4,
        TAP_EX1_DR   = 4'd5,
        TAP_PAUSE_DR = 4'd6,
        TAP_EX2_DR   = 4'd7,
        TAP_UPD_DR   = 4'd8,
        TAP_SEL_IR   = 4'd9,
        TAP_CAP_IR   = 4'd10,
        TAP_SH_IR    = 4'd11,
        TAP_EX1_IR   = 4'd12,
        TAP_PAUSE_IR = 4'd13,
        TAP_EX2_IR   = 4'd14,
        TAP_UPD_IR   = 4'd15
    } tap_state_e;

    // Data register currently routed between TDI and TDO.
    typedef enum logic [1:0] {
        DR_SEL_BYPASS = 2'd0,
        DR_SEL_IDCODE = 2'd1,
        DR_SEL_USER   = 2'd2
    } dr_sel_e;

    localparam int          JTAG_IR_LEN  = 5;
    localparam int          JTAG_DR_LEN  = 32;

    // Instruction codes for the default 5-bit IR. BYPASS is all ones for
    // any IR length; every undecoded instruction also selects BYPASS.
    localparam int unsigned INSTR_IDCODE = 32'h01;
    localparam int unsigned INSTR_USER   = 32'h11;
    localparam int unsigned INSTR_BYPASS = 32'h1F;

    // True in the two states where TDO carries scan data.
    function automatic logic tap_is_shift(input tap_state_e s);
        return (s == TAP_SH_IR) || (s == TAP_SH_DR);
    endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Brings the asynchronous JTAG pins into the clock domain: per bit a
// two-flop synchronizer followed by one history flop, with rise/fall
// strobes derived from the synchronized and history values.
module jtag_sync_edge
    import jtag_pkg::*;
#(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] sync_out,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic [W-1:0] hist_q;

    // Synchronizer pipeline; reset values match the idle level of each pin
    // so releasing reset never manufactures an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            hist_q <= RST_VAL;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~hist_q;
    assign fall     = ~sync_q & hist_q;

endmodule

// File: rtl/jtag_tap_responder.sv
// JTAG TAP responder running entirely on the system clock, which
// oversamples TCK. Provides IDCODE, a 32-bit user data register and BYPASS.
//
// state        | meaning
// -------------+-----------------------------------------------
// TAP_TLR      | test-logic-reset, IR forced to IDCODE
// TAP_RTI      | run-test/idle
// TAP_SEL_DR   | select DR scan
// TAP_CAP_DR   | load selected DR on the leaving TCK rise
// TAP_SH_DR    | shift selected DR LSB-first
// TAP_EX1_DR   | exit-1 DR
// TAP_PAUSE_DR | hold DR shift contents
// TAP_EX2_DR   | exit-2 DR
// TAP_UPD_DR   | user DR written out on entry
// TAP_SEL_IR   | select IR scan
// TAP_CAP_IR   | load IR shifter with ...01
// TAP_SH_IR    | shift IR LSB-first
// TAP_EX1_IR   | exit-1 IR
// TAP_PAUSE_IR | hold IR shift contents
// TAP_EX2_IR   | exit-2 IR
// TAP_UPD_IR   | IR shifter copied to active IR on entry
module jtag_tap_responder
    import jtag_pkg::*;
#(
    parameter logic [31:0]       IDCODE  = 32'h0000_0001,
    parameter int                IR_LEN  = JTAG_IR_LEN,
    parameter logic [IR_LEN-1:0] USER_IR = IR_LEN'(INSTR_USER)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              jtag_TCK,
    input  logic              jtag_TMS,
    input  logic              jtag_TDI,
    input  logic              jtag_TRSTn,
    output logic              jtag_TDO_data,
    output logic              jtag_TDO_driven,
    input  logic [31:0]       user_rdata,
    output logic [31:0]       user_wdata,
    output logic              user_wvalid,
    output logic [IR_LEN-1:0] ir_out
);

    localparam logic [IR_LEN-1:0] IR_IDCODE   = IR_LEN'(INSTR_IDCODE);
    localparam logic [IR_LEN-1:0] IR_CAPTURE  = IR_LEN'(1);
    localparam logic [31:0]       IDCODE_EFF  = IDCODE | 32'h0000_0001;
    // Pin order {TRSTn, TDI, TMS, TCK}; idle levels 1, 0, 1, 0.
    localparam logic [3:0]        PIN_RST_VAL = 4'b1010;

    logic [3:0] pins_sync;
    logic [3:0] pins_rise;
    logic [3:0] pins_fall;

    logic tck_rise;
    logic tck_fall;
    logic tms;
    logic tdi;
    logic trst_n;

    logic unused_edges;

    tap_state_e        state_q;
    tap_state_e        state_d;
    dr_sel_e           dr_sel;
    logic [31:0]       dr_capture;
    logic              shift_active;
    logic              tdo_next;
    logic              enter_upd_dr;
    logic              enter_upd_ir;

    logic [IR_LEN-1:0] ir_shift_q;
    logic [IR_LEN-1:0] ir_q;
    logic [31:0]       dr_shift_q;
    logic [31:0]       user_wdata_q;
    logic              wvalid_q;
    logic              tdo_q;
    logic              tdo_drv_q;

    jtag_sync_edge #(
        .W       (4),
        .RST_VAL (PIN_RST_VAL)
    ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in ({jtag_TRSTn, jtag_TDI, jtag_TMS, jtag_TCK}),
        .sync_out (pins_sync),
        .rise     (pins_rise),
        .fall     (pins_fall)
    );

    assign tck_rise = pins_rise[0];
    assign tck_fall = pins_fall[0];
    assign tms      = pins_sync[1];
    assign tdi      = pins_sync[2];
    assign trst_n   = pins_sync[3];

    // Only TCK needs edge strobes; the other pins are used as levels.
    assign unused_edges = ^{pins_rise[3:1], pins_fall[3:1]};

    // TAP state register: TRSTn overrides any simultaneous TCK rise.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= TAP_TLR;
        end else if (!trst_n) begin
            state_q <= TAP_TLR;
        end else if (tck_rise) begin
            state_q <= state_d;
        end
    end

    // Next-state decode, DR selection and TDO source.
    always_comb begin
        state_d      = state_q;
        dr_sel       = DR_SEL_BYPASS;
        dr_capture   = 32'h0;
        shift_active = tap_is_shift(state_q);
        tdo_next     = 1'b0;

        case (state_q)
            TAP_TLR:      state_d = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:      state_d = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR:   state_d = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR:   state_d = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:    state_d = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR:   state_d = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_d = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
            TAP_EX2_DR:   state_d = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR:   state_d = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR:   state_d = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR:   state_d = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:    state_d = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR:   state_d = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_d = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
            TAP_EX2_IR:   state_d = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR:   state_d = tms ? TAP_SEL_DR : TAP_RTI;
            default:      state_d = TAP_TLR;
        endcase

        // IDCODE takes priority should USER_IR ever be configured to alias it.
        if (ir_q == IR_IDCODE) begin
            dr_sel     = DR_SEL_IDCODE;
            dr_capture = IDCODE_EFF;
        end else if (ir_q == USER_IR) begin
            dr_sel     = DR_SEL_USER;
            dr_capture = user_rdata;
        end

        if (state_q == TAP_SH_IR) begin
            tdo_next = ir_shift_q[0];
        end else if (state_q == TAP_SH_DR) begin
            tdo_next = dr_shift_q[0];
        end

        enter_upd_dr = tck_rise && (state_d == TAP_UPD_DR) && (state_q != TAP_UPD_DR);
        enter_upd_ir = tck_rise && (state_d == TAP_UPD_IR) && (state_q != TAP_UPD_IR);
    end

    // Shift/capture/update datapath and the TDO pins, which move only on TCK fall.
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_shift_q   <= '0;
            ir_q         <= IR_IDCODE;
            dr_shift_q   <= 32'h0;
            user_wdata_q <= 32'h0;
            wvalid_q     <= 1'b0;
            tdo_q        <= 1'b0;
            tdo_drv_q    <= 1'b0;
        end else begin
            wvalid_q <= 1'b0;

            if (!trst_n) begin
                ir_q <= IR_IDCODE;
            end else if (tck_rise) begin
                case (state_q)
                    TAP_CAP_IR: ir_shift_q <= IR_CAPTURE;
                    TAP_SH_IR:  ir_shift_q <= {tdi, ir_shift_q[IR_LEN-1:1]};
                    TAP_CAP_DR: dr_shift_q <= dr_capture;
                    TAP_SH_DR: begin
                        if (dr_sel == DR_SEL_BYPASS) begin
                            dr_shift_q <= {31'h0, tdi};
                        end else begin
                            dr_shift_q <= {tdi, dr_shift_q[31:1]};
                        end
                    end
                    default: ;
                endcase

                if (state_d == TAP_TLR) begin
                    ir_q <= IR_IDCODE;
                end else if (enter_upd_ir) begin
                    ir_q <= ir_shift_q;
                end

                if (enter_upd_dr && (dr_sel == DR_SEL_USER)) begin
                    user_wdata_q <= dr_shift_q;
                    wvalid_q     <= 1'b1;
                end
            end

            if (tck_fall) begin
                tdo_q     <= tdo_next;
                tdo_drv_q <= shift_active;
            end
        end
    end

    assign jtag_TDO_data   = tdo_q;
    assign jtag_TDO_driven = tdo_drv_q;
    assign user_wdata      = user_wdata_q;
    assign user_wvalid     = wvalid_q;
    assign ir_out          = ir_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Bench for jtag_tap_responder: bit-banged TCK at 10 system clocks per
// period, scans modelled as "captured value followed by TDI" bit strings.
module tb_jtag_tap_responder;

    localparam logic [4:0]  IR_ID   = 5'h01;
    localparam logic [4:0]  IR_USER = 5'h11;
    localparam logic [4:0]  IR_BYP  = 5'h1F;
    localparam logic [31:0] ID_VAL  = 32'h0000_0001;

    logic        clock = 1'b0;
    logic        reset;
    logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
    logic        jtag_TDO_data, jtag_TDO_driven;
    logic [31:0] user_rdata;
    logic [31:0] user_wdata;
    logic        user_wvalid;
    logic [4:0]  ir_out;

    int          total = 0;
    int          bad = 0;
    int          wv_cnt = 0;
    logic [31:0] wv_last = 32'h0;
    int          drv_total = 0;

    jtag_tap_responder dut (
        .clock           (clock),
        .reset           (reset),
        .jtag_TCK        (jtag_TCK),
        .jtag_TMS        (jtag_TMS),
        .jtag_TDI        (jtag_TDI),
        .jtag_TRSTn      (jtag_TRSTn),
        .jtag_TDO_data   (jtag_TDO_data),
        .jtag_TDO_driven (jtag_TDO_driven),
        .user_rdata      (user_rdata),
        .user_wdata      (user_wdata),
        .user_wvalid     (user_wvalid),
        .ir_out          (ir_out)
    );

    always #5 clock = ~clock;

    // Each clock of user_wvalid high is one count; a clean pulse adds exactly 1.
    always @(negedge clock) begin
        if (user_wvalid === 1'b1) begin
            wv_cnt  = wv_cnt + 1;
            wv_last = user_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One TCK period; TDO is sampled late in the low phase, as a probe would.
    task automatic tck(input logic tms, input logic tdi, output logic tdo, output logic drv);
        jtag_TCK = 1'b0;
        jtag_TMS = tms;
        jtag_TDI = tdi;
        repeat (5) @(posedge clock);
        #1;
        tdo = jtag_TDO_data;
        drv = jtag_TDO_driven;
        if (drv === 1'b1) drv_total++;
        jtag_TCK = 1'b1;
        repeat (5) @(posedge clock);
        #1;
    endtask

    task automatic step(input logic tms);
        logic o, d;
        tck(tms, 1'b0, o, d);
    endtask

    // Full scan starting and ending in Run-Test/Idle, optional pause after bit pause_at.
    task automatic scan(input bit is_ir, input int n, input logic [63:0] tdi,
                        input int pause_at, input int pause_len, output logic [63:0] tdo_bits);
        logic o, d;
        tdo_bits  = '0;
        drv_total = 0;
        step(1'b1);
        if (is_ir) step(1'b1);
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < n; i++) begin
            tck((i == n - 1) || (i == pause_at), tdi[i], o, d);
            tdo_bits[i] = o;
            if ((i == pause_at) && (i != n - 1)) begin
                for (int k = 0; k < pause_len; k++) step(1'b0);
                step(1'b1);
                step(1'b0);
            end
        end
        step(1'b1);
        step(1'b0);
    endtask

    // Bit string seen at TDO / left in the register: captured bits first, then TDI.
    function automatic logic [127:0] cat_of(input logic [63:0] tdi, input logic [31:0] cap, input int cap_len);
        logic [127:0] c;
        c = {64'h0, tdi} << cap_len;
        c = c | {96'h0, cap};
        return c;
    endfunction

    function automatic logic [63:0] first_n(input logic [127:0] v, input int n);
        logic [63:0] m;
        m = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
        return v[63:0] & m;
    endfunction

    function automatic logic [31:0] left_after(input logic [127:0] v, input int n);
        logic [127:0] s;
        s = v >> n;
        return s[31:0];
    endfunction

    task automatic load_ir(input logic [4:0] val, input string tag);
        logic [63:0] t;
        scan(1'b1, 5, {59'h0, val}, -1, 0, t);
        check({tag, "_ir_capture"}, t, first_n(cat_of({59'h0, val}, 32'h1, 5), 5));
        check({tag, "_ir_out"}, 64'(ir_out), 64'(val));
    endtask

    task automatic do_reset();
        jtag_TCK = 1'b0;
        jtag_TMS = 1'b1;
        jtag_TDI = 1'b0;
        jtag_TRSTn = 1'b1;
        reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
    endtask

    initial begin
        logic [63:0]  t;
        logic [63:0]  tdi64;
        logic [31:0]  wa;
        logic [127:0] c;
        logic [4:0]   irv;
        logic         o, d;
        int           w0, n, pa, kind, dlen;

        user_rdata = 32'h0;
        do_reset();
        check("rst_ir_out", 64'(ir_out), 64'(IR_ID));
        check("rst_tdo", 64'(jtag_TDO_data), 64'h0);
        check("rst_tdo_driven", 64'(jtag_TDO_driven), 64'h0);
        check("rst_wvalid_cnt", 64'(wv_cnt), 64'h0);
        check("rst_wdata", 64'(user_wdata), 64'h0);

        // IDCODE straight out of reset.
        step(1'b0);
        scan(1'b0, 32, 64'h0, -1, 0, t);
        check("idcode_tdo", t, 64'(ID_VAL));
        check("idcode_driven_bits", 64'(drv_total), 64'd32);

        // User register read/write.
        load_ir(IR_USER, "user");
        user_rdata = 32'hDEAD_BEEF;
        w0 = wv_cnt;
        scan(1'b0, 32, 64'h1234_5678, -1, 0, t);
        check("user_tdo", t, 64'h0000_0000_DEAD_BEEF);
        check("user_driven_bits", 64'(drv_total), 64'd32);
        check("user_wvalid_once", 64'(wv_cnt - w0), 64'd1);
        check("user_wdata_at_pulse", 64'(wv_last), 64'h1234_5678);
        check("user_wdata", 64'(user_wdata), 64'h1234_5678);

        // BYPASS: captured 0, then TDI delayed one bit.
        load_ir(IR_BYP, "byp");
        w0 = wv_cnt;
        scan(1'b0, 9, 64'hA5, -1, 0, t);
        check("bypass_tdo", t, first_n(cat_of(64'hA5, 32'h0, 1), 9));
        check("bypass_no_wvalid", 64'(wv_cnt - w0), 64'd0);

        // Five TMS=1 from Shift-DR reaches Test-Logic-Reset.
        load_ir(IR_USER, "tlr");
        user_rdata = 32'h0F1E_2D3C;
        w0 = wv_cnt;
        step(1'b1); step(1'b0); step(1'b0);
        for (int k = 0; k < 5; k++) step(1'b1);
        check("tlr_ir_out", 64'(ir_out), 64'(IR_ID));
        check("tlr_passing_upd_wdata", 64'(user_wdata), 64'(left_after(cat_of(64'h0, user_rdata, 32), 1)));
        check("tlr_passing_upd_cnt", 64'(wv_cnt - w0), 64'd1);
        step(1'b0);
        scan(1'b0, 32, 64'h0, -1, 0, t);
        check("tlr_then_idcode", t, 64'(ID_VAL));

        // TRSTn pulse in the middle of a user shift.
        load_ir(IR_USER, "trst");
        w0 = wv_cnt;
        step(1'b1); step(1'b0); step(1'b0);
        for (int k = 0; k < 5; k++) tck(1'b0, 1'b1, o, d);
        jtag_TRSTn = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        jtag_TRSTn = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("trst_ir_out", 64'(ir_out), 64'(IR_ID));
        check("trst_no_wvalid", 64'(wv_cnt - w0), 64'd0);
        tck(1'b0, 1'b0, o, d);
        check("trst_tdo_released", 64'(d), 64'h0);

        // Synchronous reset in the middle of a user shift.
        load_ir(IR_USER, "rstmid");
        w0 = wv_cnt;
        step(1'b1); step(1'b0); step(1'b0);
        for (int k = 0; k < 3; k++) tck(1'b0, 1'b1, o, d);
        do_reset();
        check("rstmid_no_wvalid", 64'(wv_cnt - w0), 64'd0);
        check("rstmid_wdata", 64'(user_wdata), 64'h0);
        check("rstmid_ir_out", 64'(ir_out), 64'(IR_ID));
        check("rstmid_driven", 64'(jtag_TDO_driven), 64'h0);
        step(1'b0);

        // Pause-DR in the middle of a user write must not lose bits.
        load_ir(IR_USER, "pause");
        tdi64 = {32'h0, $urandom};
        user_rdata = $urandom;
        scan(1'b0, 32, tdi64, -1, 0, t);
        wa = user_wdata;
        check("pause_ref_wdata", 64'(wa), 64'(tdi64[31:0]));
        pa = $urandom_range(0, 30);
        w0 = wv_cnt;
        scan(1'b0, 32, tdi64, pa, 10, t);
        check("pause_tdo", t, 64'(user_rdata));
        check("pause_driven_bits", 64'(drv_total), 64'd32);
        check("pause_wdata_same", 64'(user_wdata), 64'(wa));
        check("pause_wvalid_once", 64'(wv_cnt - w0), 64'd1);

        // Randomized scans against the bit-string model.
        for (int it = 0; it < 10; it++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: irv = IR_ID;
                1: irv = IR_USER;
                2: irv = IR_BYP;
                default: begin
                    irv = 5'($urandom);
                    if ((irv == IR_ID) || (irv == IR_USER)) irv = 5'h02;
                end
            endcase
            load_ir(irv, "rnd");
            user_rdata = $urandom;
            n = $urandom_range(1, 40);
            tdi64 = {$urandom, $urandom};
            pa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
            if (irv == IR_ID) begin
                c = cat_of(tdi64, ID_VAL | 32'h1, 32);
            end else if (irv == IR_USER) begin
                c = cat_of(tdi64, user_rdata, 32);
            end else begin
                c = cat_of(tdi64, 32'h0, 1);
            end
            dlen = n;
            w0 = wv_cnt;
            scan(1'b0, n, tdi64, pa, $urandom_range(1, 4), t);
            check("rnd_tdo", t, first_n(c, n));
            check("rnd_driven_bits", 64'(drv_total), 64'(dlen));
            if (irv == IR_USER) begin
                check("rnd_user_wvalid", 64'(wv_cnt - w0), 64'd1);
                check("rnd_user_wdata", 64'(user_wdata), 64'(left_after(c, n)));
            end else begin
                check("rnd_other_wvalid", 64'(wv_cnt - w0), 64'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
